mult_seq_param: RTL and testbench



---
 rtl/mult_seq_param.sv | 166 ++++++++++++++++
 tb/tb_mult_seq_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param: digit-serial shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Retires DIGIT multiplier bits per cycle; fixed latency of WIDTH/DIGIT edges
// from operand join to product valid, then holds the product until accepted.
// Optional feature macro: MULT_SEQ_SIGNED_EN (two's-complement operands).
// Without it the core is purely unsigned and carries no sign logic.
`timescale 1ns/1ps

module mult_seq_param #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a_tdata,
    input  logic                 input_a_tvalid,
    output logic                 input_a_tready,
    input  logic [WIDTH-1:0]     input_b_tdata,
    input  logic                 input_b_tvalid,
    output logic                 input_b_tready,
    output logic [2*WIDTH-1:0]   output_tdata,
    output logic                 output_tvalid,
    input  logic                 output_tready
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = WIDTH + DIGIT;
    localparam int unsigned AW    = 2 * WIDTH;
    localparam int unsigned SH_W  = $clog2(AW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [AW-1:0]      data_q, data_d;
`ifdef MULT_SEQ_SIGNED_EN
    logic               sign_q, sign_d;
`endif

    logic               accept_c;
    logic [PW-1:0]      pp_c;
    logic [SH_W-1:0]    shamt_c;
    logic [AW-1:0]      sum_c;
    logic [AW-1:0]      res_c;
    logic [WIDTH-1:0]   op_a_c;
    logic [WIDTH-1:0]   op_b_c;

    assign input_a_tready = ready_q;
    assign input_b_tready = ready_q;
    assign output_tvalid  = valid_q;
    assign output_tdata   = data_q;

    // Datapath: join detect, operand conditioning, one partial-product step.
    always_comb begin
        accept_c = (state_q == IDLE) && ready_q && input_a_tvalid && input_b_tvalid;
`ifdef MULT_SEQ_SIGNED_EN
        // Magnitudes fit in WIDTH bits unsigned, including the most-negative value.
        op_a_c = input_a_tdata[WIDTH-1] ? (~input_a_tdata + WIDTH'(1)) : input_a_tdata;
        op_b_c = input_b_tdata[WIDTH-1] ? (~input_b_tdata + WIDTH'(1)) : input_b_tdata;
`else
        op_a_c = input_a_tdata;
        op_b_c = input_b_tdata;
`endif
        pp_c    = PW'(a_q) * PW'(b_q[DIGIT-1:0]);
        // Iteration index i = N-1-counter; digit i has weight 2^(DIGIT*i).
        shamt_c = SH_W'(CNT_W'(N - 1) - cnt_q) * SH_W'(DIGIT);
        sum_c   = acc_q + (AW'(pp_c) << shamt_c);
`ifdef MULT_SEQ_SIGNED_EN
        res_c   = sign_q ? (~sum_c + AW'(1)) : sum_c;
`else
        res_c   = sum_c;
`endif
    end

    // Next-state and register-input logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef MULT_SEQ_SIGNED_EN
        sign_d  = sign_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d     = op_a_c;
                    b_d     = op_b_c;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(N - 1);
                    state_d = BUSY;
`ifdef MULT_SEQ_SIGNED_EN
                    sign_d  = input_a_tdata[WIDTH-1] ^ input_b_tdata[WIDTH-1];
`endif
                end
            end
            BUSY: begin
                acc_d = sum_c;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = res_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (valid_q && output_tready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Ready is asserted for every cycle spent in IDLE, including the bubble.
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset aborts any in-flight product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef MULT_SEQ_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Testbench for mult_seq_param (WIDTH=64, DIGIT=4): directed corner cases plus
// randomized operand pairs, join skew and output back-pressure, checked against
// a plain-arithmetic product model. Honours MULT_SEQ_SIGNED_EN when defined.
`timescale 1ns/1ps

module tb_mult_seq_param;

    localparam int unsigned W = 64;
    localparam int unsigned D = 4;
    localparam int unsigned N = W / D;

    typedef logic [2*W-1:0] prod_t;

    logic           clk;
    logic           rst;
    logic [W-1:0]   input_a_tdata;
    logic           input_a_tvalid;
    logic           input_a_tready;
    logic [W-1:0]   input_b_tdata;
    logic           input_b_tvalid;
    logic           input_b_tready;
    prod_t          output_tdata;
    logic           output_tvalid;
    logic           output_tready;

    int unsigned    n_cmp;
    int unsigned    n_mis;

    mult_seq_param #(.WIDTH(W), .DIGIT(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_a_tdata  (input_a_tdata),
        .input_a_tvalid (input_a_tvalid),
        .input_a_tready (input_a_tready),
        .input_b_tdata  (input_b_tdata),
        .input_b_tvalid (input_b_tvalid),
        .input_b_tready (input_b_tready),
        .output_tdata   (output_tdata),
        .output_tvalid  (output_tvalid),
        .output_tready  (output_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input prod_t got, input prod_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product from plain full-width arithmetic.
    function automatic prod_t ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SEQ_SIGNED_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        return prod_t'(sa * sb);
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Waits (bounded) for the join handshake; call just after a rising edge.
    task automatic wait_accept(output bit accepted);
        bit rdy;
        accepted = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = input_a_tready && input_b_tready && input_a_tvalid && input_b_tvalid;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        check_eq("accept", prod_t'(accepted), prod_t'(1));
    endtask

    // One full transaction: optional single-sided lead, latency, hold, handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lead, input bit b_first, input int stall);
        prod_t exp;
        prod_t held;
        bit    accepted;
        bit    busy_ok;
        int    lat;
        exp = ref_mul(a, b);
        output_tready  = (stall == 0);
        input_a_tdata  = a;
        input_b_tdata  = b;
        input_a_tvalid = !b_first || (lead == 0);
        input_b_tvalid = b_first || (lead == 0);
        for (int i = 0; i < lead; i++) begin
            @(posedge clk);
            #1;
            check_eq("lone_valid_no_accept", prod_t'(input_a_tready && input_b_tready), prod_t'(1));
        end
        input_a_tvalid = 1'b1;
        input_b_tvalid = 1'b1;
        wait_accept(accepted);
        input_a_tvalid = 1'b0;
        input_b_tvalid = 1'b0;
        input_a_tdata  = {$urandom, $urandom};
        input_b_tdata  = {$urandom, $urandom};
        busy_ok = 1'b1;
        lat     = 0;
        for (int k = 1; k <= 4 * int'(N); k++) begin
            if (input_a_tready || input_b_tready || output_tvalid) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat = k;
            if (output_tvalid) break;
        end
        check_eq("busy_ready_low", prod_t'(busy_ok), prod_t'(1));
        check_eq("latency", prod_t'(lat), prod_t'(N));
        check_eq("product", output_tdata, exp);
        held = output_tdata;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", prod_t'(output_tvalid), prod_t'(1));
            check_eq("hold_data", output_tdata, held);
        end
        output_tready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("valid_drop", prod_t'(output_tvalid), prod_t'(0));
        check_eq("ready_back", prod_t'(input_a_tready && input_b_tready), prod_t'(1));
    endtask

    // Abort an operation with reset part-way through BUSY.
    task automatic abort_op(input int iters);
        bit accepted;
        input_a_tdata  = {$urandom, $urandom};
        input_b_tdata  = {$urandom, $urandom};
        input_a_tvalid = 1'b1;
        input_b_tvalid = 1'b1;
        wait_accept(accepted);
        input_a_tvalid = 1'b0;
        input_b_tvalid = 1'b0;
        repeat (iters) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("abort_ready_a", prod_t'(input_a_tready), prod_t'(0));
        check_eq("abort_ready_b", prod_t'(input_b_tready), prod_t'(0));
        check_eq("abort_valid", prod_t'(output_tvalid), prod_t'(0));
        check_eq("abort_data", output_tdata, prod_t'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_ready_after", prod_t'(input_a_tready && input_b_tready), prod_t'(1));
    endtask

    initial begin
        n_cmp          = 0;
        n_mis          = 0;
        rst            = 1'b0;
        input_a_tdata  = '0;
        input_a_tvalid = 1'b0;
        input_b_tdata  = '0;
        input_b_tvalid = 1'b0;
        output_tready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready_a", prod_t'(input_a_tready), prod_t'(0));
        check_eq("rst_ready_b", prod_t'(input_b_tready), prod_t'(0));
        check_eq("rst_valid", prod_t'(output_tvalid), prod_t'(0));
        check_eq("rst_data", output_tdata, prod_t'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_ready", prod_t'(input_a_tready && input_b_tready), prod_t'(1));

        run_op(64'd3, 64'd5, 0, 1'b0, 0);
        run_op('1, '1, 0, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FE29, 64'h7FFF_FFFF_FFFF_FE29, 5, 1'b0, 0);
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1'b0, 10);
        run_op(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_CAFE_F00D, 0, 1'b0, 0);
        run_op(64'h0, 64'hFFFF_0000_FFFF_0000, 3, 1'b1, 0);

        abort_op(7);
        run_op(64'd7, 64'd9, 0, 1'b0, 0);

`ifdef MULT_SEQ_SIGNED_EN
        run_op(-64'sd3, 64'd5, 0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 0, 1'b0, 0);
`endif

        for (int t = 0; t < 24; t++) begin
            run_op(pick_operand(), pick_operand(), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
